// File: rtl/adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package adder_pkg;

    // Width of one carry-lookahead slice.
    localparam int NIB_W = 4;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow: the carry into the MSB differs from the carry out of it.
    // The carry into the MSB is recovered from the MSB operand and sum bits.
    function automatic logic calc_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb, input logic cout);
        return (a_msb ^ b_msb ^ s_msb) ^ cout;
    endfunction

endpackage

// File: rtl/adder_ahead_4.sv
// 4-bit carry-lookahead adder slice with group generate/propagate outputs.
module AdderAhead_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       g,
    output logic       p
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;

    // Lookahead carries computed directly from bit generate/propagate terms.
    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        c[0] = cin;
        c[1] = gen[0] | (prop[0] & cin);
        c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
        c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cin);
        c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
        sum  = prop ^ c[3:0];
        cout = c[4];
        g    = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0]);
        p    = &prop;
    end

endmodule

// File: rtl/adder_nibble_serial.sv
// Multi-cycle adder: one 4-bit CLA slice reused LSB nibble first, carry kept in a register.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// in_ready_o is high only in IDLE, out_valid_o only in DONE, and out_valid_o stays high
// with stable sum/cout/ovf until the transfer (or reset). WIDTH must be a multiple of 4.
module adder_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [1:0]       dbg_state_o
);

    import adder_pkg::*;

    localparam int NIB   = WIDTH / NIB_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               last_nib;

    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_cout;
    logic               slice_g_unused;
    logic               slice_p_unused;

    assign last_nib = (cnt == CNT_W'(NIB - 1));
    assign slice_a  = a_q[NIB_W*int'(cnt) +: NIB_W];
    assign slice_b  = b_q[NIB_W*int'(cnt) +: NIB_W];

    AdderAhead_4 u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout),
        .g    (slice_g_unused),
        .p    (slice_p_unused)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: accept in IDLE, walk the nibbles in RUN, wait for the consumer in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid_i)  state_nxt = RUN;
            RUN:     if (last_nib)    state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
        dbg_state_o = state;
    end

    // Operand capture, per-nibble sum assembly and final carry/overflow registration.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    sum_q[NIB_W*int'(cnt) +: NIB_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (last_nib) begin
                        cout_q <= slice_cout;
                        ovf_q  <= calc_ovf(a_q[WIDTH-1], b_q[WIDTH-1],
                                           slice_sum[NIB_W-1], slice_cout);
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_adder_nibble_serial.sv
// Directed bench for adder_nibble_serial (WIDTH=16) with an expected-result queue.
module tb_adder_nibble_serial;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   dbg_state;

    // {sum, cout, ovf}
    logic [W+1:0] exp_q[$];
    int           n_cmp;
    int           n_err;

    adder_nibble_serial #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .cin_i       (cin),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum_o       (sum),
        .cout_o      (cout),
        .ovf_o       (ovf),
        .dbg_state_o (dbg_state)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) until the DUT can accept, then present one operand set for one edge.
    task automatic drive_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        exp_q.push_back({es, ec, eo});
        drive_op(av, bv, cv);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every handed-off result against the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got sum=0x%0h cout=%0b ovf=%0b", sum, cout, ovf);
            end else begin
                check("result", 32'({sum, cout, ovf}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int edges;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: counting the accept edge as edge 1, out_valid is high after edge 5.
        issue(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency_edges", 32'(edges), 32'd5);
        drain();

        // Overflow and carry corners, issued back to back.
        issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        drain();

        // Backpressure: result must hold for 6 cycles while the consumer stalls.
        out_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        for (int i = 0; i < 6; i++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_sum",       32'(sum),       32'h5556);
            check("bp_cout",      32'(cout),      32'd0);
            check("bp_ovf",       32'(ovf),       32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        drain();

        // Input churn during RUN must not disturb the captured operands.
        issue(16'h0F0F, 16'h1111, 1'b0, 16'h2020, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a = 16'(32'h0000_A5A5 + 32'(i));
            b = 16'hFFFF;
            cin = 1'b1;
            in_valid = ~in_valid;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset two nibbles into an operation: nothing from it may ever be presented.
        drive_op(16'h1111, 16'h2222, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_sum",       32'(sum),       32'd0);
        check("abort_cout",      32'(cout),      32'd0);
        check("abort_ovf",       32'(ovf),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
